wb_arbiter: RTL and testbench

// Shares the single regfile write port among NUM_REQ execution-unit result ports.

---
 rtl/wb_arbiter.sv | 101 ++++++++++
 tb/tb_wb_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NUM_REQ result ports.
// One registered output stage plus a combinational one-hot unlock pulse on write acceptance.
module wb_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int XLEN    = 64,
    parameter  int NR      = 64,
    localparam int RW      = $clog2(NR)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*RW-1:0]   req_rd_i,
    input  logic [NUM_REQ*XLEN-1:0] req_data_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [RW-1:0]           wb_rd_o,
    output logic [XLEN-1:0]         wb_data_o,
    output logic [NR-1:0]           unlock_o
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      ptr_q, ptr_d;
    logic               wb_valid_q, wb_valid_d;
    logic [RW-1:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;

    logic               flush;
    logic               load_en;
    logic               xfer;
    logic               gnt_found;
    int                 gnt_sel;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [RW-1:0]      sel_rd;
    logic [XLEN-1:0]    sel_data;

    assign flush   = rst_i | clear_i;
    assign load_en = ~wb_valid_q | wb_ready_i;

    // Scan from ptr upward with wrap; the first valid requester wins.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        gnt_found = 1'b0;
        gnt_sel   = 0;
        gnt_vec   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_sel   = (int'(ptr_q) + k) % NUM_REQ;
            end
        end
        if (gnt_found) begin
            gnt_vec[gnt_sel] = 1'b1;
        end
    end

    assign xfer        = gnt_found & load_en & ~flush;
    assign req_ready_o = gnt_vec & {NUM_REQ{load_en & ~flush}};
    assign sel_rd      = req_rd_i[gnt_sel*RW +: RW];
    assign sel_data    = req_data_i[gnt_sel*XLEN +: XLEN];

    always_comb begin
        ptr_d      = ptr_q;
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        if (load_en) begin
            wb_valid_d = 1'b0;
            if (xfer) begin
                wb_rd_d    = sel_rd;
                wb_data_d  = sel_data;
                // x0 writes are consumed but never reach the regfile.
                wb_valid_d = (sel_rd != '0);
                ptr_d      = (gnt_sel == NUM_REQ - 1) ? '0 : PW'(gnt_sel + 1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_i) begin
        if (flush) begin
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign unlock_o   = (wb_valid_q && wb_ready_i) ? (NR'(1) << wb_rd_q) : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a directed vector table followed by a
// hand-written round-robin sequence under intermittent backpressure.
module tb_wb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int XLEN    = 64;
    localparam int NR      = 64;
    localparam int RW      = 6;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      clear_i;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ-1:0][RW-1:0]   req_rd_i;
    logic [NUM_REQ-1:0][XLEN-1:0] req_data_i;
    logic                      wb_valid_o;
    logic                      wb_ready_i;
    logic [RW-1:0]             wb_rd_o;
    logic [XLEN-1:0]           wb_data_o;
    logic [NR-1:0]             unlock_o;

    wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .NR(NR)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_rd_i    (req_rd_i),
        .req_data_i  (req_data_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_rd_o     (wb_rd_o),
        .wb_data_o   (wb_data_o),
        .unlock_o    (unlock_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic                         rst;
        logic                         clr;
        logic [3:0]                   valid;
        logic [NUM_REQ-1:0][RW-1:0]   rd;
        logic [NUM_REQ-1:0][XLEN-1:0] d;
        logic                         wbr;
        logic [3:0]                   exp_ready;
        logic                         exp_valid;
        logic [RW-1:0]                exp_rd;
        logic [XLEN-1:0]              exp_data;
        logic [NR-1:0]                exp_unlock;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[$];

    logic [NUM_REQ-1:0][RW-1:0]   rr_rd = {6'd4, 6'd3, 6'd2, 6'd1};
    logic [NUM_REQ-1:0][XLEN-1:0] rr_d  = {64'h1000_0000_0000_4444, 64'h2000_0000_0000_3333,
                                           64'h4000_0000_0000_2222, 64'h8000_0000_0000_1111};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic rst, input logic clr, input logic [3:0] valid,
        input logic [NUM_REQ-1:0][RW-1:0] rd, input logic [NUM_REQ-1:0][XLEN-1:0] d,
        input logic wbr, input logic [3:0] er, input logic ev, input logic [RW-1:0] erd,
        input logic [XLEN-1:0] ed, input logic [NR-1:0] eu);
        vec_t v;
        v.rst = rst; v.clr = clr; v.valid = valid; v.rd = rd; v.d = d; v.wbr = wbr;
        v.exp_ready = er; v.exp_valid = ev; v.exp_rd = erd; v.exp_data = ed; v.exp_unlock = eu;
        return v;
    endfunction

    initial begin
        int m_ptr;
        int m_idx;
        logic m_valid;
        logic exp_load;
        logic [3:0] exp_ready;
        logic [NR-1:0] exp_unlock;

        // Reset with all requesters valid, then round-robin
        tbl.push_back(mk(1,0,4'b1111, rr_rd, rr_d, 1, 4'b0000, 0, 0, 64'h0, 64'h0));
        tbl.push_back(mk(0,0,4'b1111, rr_rd, rr_d, 1, 4'b0001, 0, 0, 64'h0, 64'h0));
        tbl.push_back(mk(0,0,4'b1111, rr_rd, rr_d, 1, 4'b0010, 1, 1, 64'h8000_0000_0000_1111, 64'h2));
        tbl.push_back(mk(0,0,4'b1111, rr_rd, rr_d, 1, 4'b0100, 1, 2, 64'h4000_0000_0000_2222, 64'h4));
        tbl.push_back(mk(0,0,4'b1111, rr_rd, rr_d, 1, 4'b1000, 1, 3, 64'h2000_0000_0000_3333, 64'h8));
        tbl.push_back(mk(0,0,4'b1111, rr_rd, rr_d, 1, 4'b0001, 1, 4, 64'h1000_0000_0000_4444, 64'h10));
        // Drain, then backpressure on rd=5/0xAB
        tbl.push_back(mk(0,0,4'b0000, rr_rd, rr_d, 1, 4'b0000, 1, 1, 64'h8000_0000_0000_1111, 64'h2));
        tbl.push_back(mk(0,0,4'b0001, {6'd0,6'd0,6'd0,6'd5}, {64'h0,64'h0,64'h0,64'hAB}, 0,
                         4'b0001, 0, 1, 64'h8000_0000_0000_1111, 64'h0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,0,4'b0001, {6'd0,6'd0,6'd0,6'd6}, {64'h0,64'h0,64'h0,64'hCD}, 0,
                             4'b0000, 1, 5, 64'hAB, 64'h0));
        tbl.push_back(mk(0,0,4'b0001, {6'd0,6'd0,6'd0,6'd6}, {64'h0,64'h0,64'h0,64'hCD}, 1,
                         4'b0001, 1, 5, 64'hAB, 64'h20));
        // Move ptr to 2, then an x0 write from req2
        tbl.push_back(mk(0,0,4'b0010, {6'd0,6'd0,6'd9,6'd0}, {64'h0,64'h0,64'h99,64'h0}, 1,
                         4'b0010, 1, 6, 64'hCD, 64'h40));
        tbl.push_back(mk(0,0,4'b0100, {6'd0,6'd0,6'd0,6'd0}, {64'h0,64'h77,64'h0,64'h0}, 1,
                         4'b0100, 1, 9, 64'h99, 64'h200));
        // Wrap: ptr=3 with 1001 -> 3, 0, then ptr=1 grants 3 again
        tbl.push_back(mk(0,0,4'b1001, {6'd10,6'd0,6'd0,6'd11}, {64'h3A,64'h0,64'h0,64'h0B}, 1,
                         4'b1000, 0, 0, 64'h77, 64'h0));
        tbl.push_back(mk(0,0,4'b1001, {6'd10,6'd0,6'd0,6'd11}, {64'h3A,64'h0,64'h0,64'h0B}, 1,
                         4'b0001, 1, 10, 64'h3A, 64'h400));
        tbl.push_back(mk(0,0,4'b1001, {6'd10,6'd0,6'd0,6'd11}, {64'h3A,64'h0,64'h0,64'h0B}, 1,
                         4'b1000, 1, 11, 64'h0B, 64'h800));
        // Load rd=7, stall it, clear mid-stall with req1 valid
        tbl.push_back(mk(0,0,4'b0100, {6'd0,6'd7,6'd0,6'd0}, {64'h0,64'h70,64'h0,64'h0}, 1,
                         4'b0100, 1, 10, 64'h3A, 64'h400));
        tbl.push_back(mk(0,0,4'b0010, {6'd0,6'd0,6'd12,6'd0}, {64'h0,64'h0,64'hC0,64'h0}, 0,
                         4'b0000, 1, 7, 64'h70, 64'h0));
        tbl.push_back(mk(0,1,4'b0010, {6'd0,6'd0,6'd12,6'd0}, {64'h0,64'h0,64'hC0,64'h0}, 0,
                         4'b0000, 1, 7, 64'h70, 64'h0));
        tbl.push_back(mk(0,0,4'b0000, {6'd0,6'd0,6'd0,6'd0}, {64'h0,64'h0,64'h0,64'h0}, 1,
                         4'b0000, 0, 0, 64'h0, 64'h0));
        tbl.push_back(mk(0,0,4'b1111, rr_rd, rr_d, 1, 4'b0001, 0, 0, 64'h0, 64'h0));

        rst_i = 1'b1; clear_i = 1'b0; req_valid_i = '0; req_rd_i = '0; req_data_i = '0;
        wb_ready_i = 1'b0;
        @(posedge clk_i); #1;

        foreach (tbl[i]) begin
            rst_i       = tbl[i].rst;
            clear_i     = tbl[i].clr;
            req_valid_i = tbl[i].valid;
            req_rd_i    = tbl[i].rd;
            req_data_i  = tbl[i].d;
            wb_ready_i  = tbl[i].wbr;
            #1;
            check($sformatf("v%0d ready", i),  64'(req_ready_o), 64'(tbl[i].exp_ready));
            check($sformatf("v%0d valid", i),  64'(wb_valid_o),  64'(tbl[i].exp_valid));
            check($sformatf("v%0d rd", i),     64'(wb_rd_o),     64'(tbl[i].exp_rd));
            check($sformatf("v%0d data", i),   wb_data_o,        tbl[i].exp_data);
            check($sformatf("v%0d unlock", i), unlock_o,         tbl[i].exp_unlock);
            @(posedge clk_i); #1;
        end

        // Last table entry granted req0: ptr=1, output holds rd=1 valid.
        m_ptr = 1; m_idx = 0; m_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_valid_i = 4'b1111;
            req_rd_i    = rr_rd;
            req_data_i  = rr_d;
            wb_ready_i  = (c % 3) != 0;
            #1;
            exp_load   = !m_valid || wb_ready_i;
            exp_ready  = exp_load ? 4'(1 << m_ptr) : 4'b0000;
            exp_unlock = (m_valid && wb_ready_i) ? (NR'(1) << rr_rd[m_idx]) : '0;
            check($sformatf("rr%0d ready", c),  64'(req_ready_o), 64'(exp_ready));
            check($sformatf("rr%0d valid", c),  64'(wb_valid_o),  64'(m_valid));
            check($sformatf("rr%0d rd", c),     64'(wb_rd_o),     64'(rr_rd[m_idx]));
            check($sformatf("rr%0d data", c),   wb_data_o,        rr_d[m_idx]);
            check($sformatf("rr%0d unlock", c), unlock_o,         exp_unlock);
            if (exp_load) begin
                m_valid = 1'b1;
                m_idx   = m_ptr;
                m_ptr   = (m_ptr + 1) % NUM_REQ;
            end
            @(posedge clk_i); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
